// File: rtl/multi_way_traffic_ctrl.sv
// multi_way_traffic_ctrl: round-robin N-way traffic light controller.
// Each green can be extended once when traffic is waiting, and empty ways are skipped.
// Manual requests are latched and pre-empt the current green.
// A 2-digit BCD countdown of the current phase drives the intersection display.
// Optional macro NIGHT_FLASH_EN adds a NIGHT input that flashes all ways yellow.
module multi_way_traffic_ctrl #(
   parameter int N_WAYS    = 4,
   parameter int GREEN_MIN = 30,
   parameter int GREEN_EXT = 15,
   parameter int YELLOW    = 5,
   parameter int TICK_DIV  = 1000
) (
   input  logic                  CLK,
   input  logic                  R,
   input  logic [N_WAYS-1:0]     TRAFFIC,
   input  logic [N_WAYS-1:0]     MANUAL,
`ifdef NIGHT_FLASH_EN
   input  logic                  NIGHT,
`endif
   output logic [2*N_WAYS-1:0]   LIGHT,
   output logic [2:0]            ACTIVE_WAY,
   output logic [7:0]            COUNT_BCD
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [7:0] BCD_GMIN = 8'(((GREEN_MIN / 10) << 4) + (GREEN_MIN % 10));
   localparam logic [7:0] BCD_GEXT = 8'(((GREEN_EXT / 10) << 4) + (GREEN_EXT % 10));
   localparam logic [7:0] BCD_Y    = 8'(((YELLOW / 10) << 4) + (YELLOW % 10));
   localparam logic [7:0] BCD_ONE  = 8'h01;

   localparam logic [1:0] C_RED    = 2'b00;
   localparam logic [1:0] C_YELLOW = 2'b01;
   localparam logic [1:0] C_GREEN  = 2'b10;

   typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED, S_FLASH} state_t;

   state_t             state;
   logic [PW-1:0]      presc;
   logic [N_WAYS-1:0]  pending;
   logic               ext_used;

   logic               tick;
   logic [N_WAYS-1:0]  pend_now;
   logic [N_WAYS-1:0]  act_oh;
   logic               other_req;
   logic               own_req;
   logic               traffic_here;
   logic [2:0]         pend_sel;
   logic [2:0]         traf_sel;
   logic [N_WAYS-1:0]  sel_oh;

   // Light vector with a single way showing the given code, all others red.
   function automatic logic [2*N_WAYS-1:0] light_of(input logic [2:0] w, input logic [1:0] code);
      logic [2*N_WAYS-1:0] v;
      v = {{(2*N_WAYS-2){1'b0}}, code};
      return v << {w, 1'b0};
   endfunction

   function automatic logic [N_WAYS-1:0] onehot(input logic [2:0] w);
      logic [N_WAYS-1:0] v;
      v = {{(N_WAYS-1){1'b0}}, 1'b1};
      return v << w;
   endfunction

   // BCD decrement; the caller never decrements 01, so 00 never wraps.
   function automatic logic [7:0] bcd_dec(input logic [7:0] c);
      if (c[3:0] == 4'd0) return {c[7:4] - 4'd1, 4'd9};
      return {c[7:4], c[3:0] - 4'd1};
   endfunction

   assign tick         = (presc == PW'(TICK_DIV - 1));
   // Requests seen this cycle act immediately, not one cycle after latching.
   assign pend_now     = pending | MANUAL;
   assign act_oh       = onehot(ACTIVE_WAY);
   assign other_req    = |(pend_now & ~act_oh);
   assign own_req      = |(pend_now & act_oh);
   assign traffic_here = |(TRAFFIC & act_oh);
   assign sel_oh       = onehot(pend_sel);

   // Lowest-index pending way.
   always_comb begin
      pend_sel = 3'd0;
      for (int i = N_WAYS - 1; i >= 0; i--)
         if (pend_now[i]) pend_sel = 3'(i);
   end

   // First way after the active one with traffic; the active way is checked last.
   // The traffic vector is rotated so that bit j maps to way (active+1+j) mod N.
   always_comb begin
      logic [2*N_WAYS-1:0] dbl;
      logic [N_WAYS-1:0]   rot;
      logic [3:0]          off;
      logic [3:0]          s;
      dbl = {TRAFFIC, TRAFFIC} >> ({1'b0, ACTIVE_WAY} + 4'd1);
      rot = dbl[N_WAYS-1:0];
      off = 4'd0;
      for (int j = N_WAYS - 1; j >= 0; j--)
         if (rot[j]) off = 4'(j);
      s = {1'b0, ACTIVE_WAY} + 4'd1 + off;
      if (s >= 4'(N_WAYS)) s = s - 4'(N_WAYS);
      traf_sel = s[2:0];
   end

   // Phase FSM, countdown, prescaler, request latch and registered outputs.
   always_ff @(posedge CLK) begin
      if (!R) begin
         state      <= S_GREEN;
         ACTIVE_WAY <= 3'd0;
         COUNT_BCD  <= BCD_GMIN;
         LIGHT      <= light_of(3'd0, C_GREEN);
         presc      <= '0;
         pending    <= '0;
         ext_used   <= 1'b0;
      end else
`ifdef NIGHT_FLASH_EN
      if (NIGHT) begin
         pending   <= '0;
         COUNT_BCD <= 8'h00;
         presc     <= tick ? '0 : presc + PW'(1);
         if (state != S_FLASH) begin
            state <= S_FLASH;
            LIGHT <= {N_WAYS{C_YELLOW}};
            presc <= '0;
         end else if (tick) begin
            LIGHT <= (LIGHT == '0) ? {N_WAYS{C_YELLOW}} : '0;
         end
      end else if (state == S_FLASH) begin
         state     <= S_ALLRED;
         COUNT_BCD <= BCD_ONE;
         LIGHT     <= '0;
         presc     <= '0;
         pending   <= MANUAL;
      end else
`endif
      begin
         presc   <= tick ? '0 : presc + PW'(1);
         pending <= pend_now;
         case (state)
            S_GREEN: begin
               if (other_req) begin
                  state     <= S_YELLOW;
                  COUNT_BCD <= BCD_Y;
                  LIGHT     <= light_of(ACTIVE_WAY, C_YELLOW);
                  presc     <= '0;
                  pending   <= pend_now & ~act_oh;
               end else if (own_req) begin
                  // Request for the green way restarts its minimum green.
                  COUNT_BCD <= BCD_GMIN;
                  presc     <= '0;
                  pending   <= pend_now & ~act_oh;
               end else if (tick) begin
                  if (COUNT_BCD == BCD_ONE) begin
                     if (traffic_here && !ext_used) begin
                        COUNT_BCD <= BCD_GEXT;
                        ext_used  <= 1'b1;
                     end else begin
                        state     <= S_YELLOW;
                        COUNT_BCD <= BCD_Y;
                        LIGHT     <= light_of(ACTIVE_WAY, C_YELLOW);
                     end
                  end else begin
                     COUNT_BCD <= bcd_dec(COUNT_BCD);
                  end
               end
            end
            S_YELLOW: begin
               if (tick) begin
                  if (COUNT_BCD == BCD_ONE) begin
                     state     <= S_ALLRED;
                     COUNT_BCD <= BCD_ONE;
                     LIGHT     <= '0;
                  end else begin
                     COUNT_BCD <= bcd_dec(COUNT_BCD);
                  end
               end
            end
            S_ALLRED: begin
               if (tick) begin
                  if (COUNT_BCD == BCD_ONE) begin
                     state     <= S_GREEN;
                     COUNT_BCD <= BCD_GMIN;
                     ext_used  <= 1'b0;
                     if (|pend_now) begin
                        ACTIVE_WAY <= pend_sel;
                        LIGHT      <= light_of(pend_sel, C_GREEN);
                        pending    <= pend_now & ~sel_oh;
                     end else begin
                        ACTIVE_WAY <= traf_sel;
                        LIGHT      <= light_of(traf_sel, C_GREEN);
                     end
                  end else begin
                     COUNT_BCD <= bcd_dec(COUNT_BCD);
                  end
               end
            end
            default: begin
               // Flash state is only reachable with night mode; recover via all-red.
               state     <= S_ALLRED;
               COUNT_BCD <= BCD_ONE;
               LIGHT     <= {C_RED, {(2*N_WAYS-2){1'b0}}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multi_way_traffic_ctrl.sv
// Scoreboard bench for multi_way_traffic_ctrl with N_WAYS=3, GREEN_MIN=4,
// GREEN_EXT=3, YELLOW=2, TICK_DIV=2. Expected per-cycle outputs are queued
// per scenario and compared one entry per clock.
module tb_multi_way_traffic_ctrl;

   localparam int N  = 3;
   localparam int TD = 2;

   localparam logic [1:0] G  = 2'b10;
   localparam logic [1:0] Y  = 2'b01;
   localparam logic [1:0] AR = 2'b00;

   typedef struct packed {
      logic [2*N-1:0] light;
      logic [2:0]     way;
      logic [7:0]     cnt;
   } exp_t;

   logic           CLK = 1'b0;
   logic           R;
   logic [N-1:0]   TRAFFIC;
   logic [N-1:0]   MANUAL;
   logic [2*N-1:0] LIGHT;
   logic [2:0]     ACTIVE_WAY;
   logic [7:0]     COUNT_BCD;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;

   multi_way_traffic_ctrl #(
      .N_WAYS(N), .GREEN_MIN(4), .GREEN_EXT(3), .YELLOW(2), .TICK_DIV(TD)
   ) dut (
      .CLK(CLK), .R(R), .TRAFFIC(TRAFFIC), .MANUAL(MANUAL),
      .LIGHT(LIGHT), .ACTIVE_WAY(ACTIVE_WAY), .COUNT_BCD(COUNT_BCD)
   );

   always #5 CLK = ~CLK;

   // Queue n cycles showing `code` on `way` with decimal count `cnt`.
   task automatic push_cnt(input logic [1:0] code, input int way, input int cnt, input int n);
      exp_t e;
      logic [2*N-1:0] l;
      l = {{(2*N-2){1'b0}}, code};
      e.light = l << (2 * way);
      e.way   = 3'(way);
      e.cnt   = 8'(((cnt / 10) << 4) | (cnt % 10));
      for (int i = 0; i < n; i++) sb.push_back(e);
   endtask

   // Queue a phase counting down from cstart for nticks ticks.
   task automatic push_phase(input logic [1:0] code, input int way, input int cstart, input int nticks);
      for (int t = 0; t < nticks; t++) push_cnt(code, way, cstart - t, TD);
   endtask

   task automatic check_cycle(input string name);
      exp_t e;
      @(posedge CLK);
      #1;
      cyc++;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s cyc%0d: no expected entry, got light=%b way=%0d cnt=%h",
                  name, cyc, LIGHT, ACTIVE_WAY, COUNT_BCD);
      end else begin
         e = sb.pop_front();
         if (LIGHT !== e.light || ACTIVE_WAY !== e.way || COUNT_BCD !== e.cnt) begin
            errors++;
            $display("FAIL %s cyc%0d: got light=%b way=%0d cnt=%h, want light=%b way=%0d cnt=%h",
                     name, cyc, LIGHT, ACTIVE_WAY, COUNT_BCD, e.light, e.way, e.cnt);
         end
      end
   endtask

   task automatic end_check(input string name);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d expected entries left, want 0", name, sb.size());
      end
      sb.delete();
   endtask

   task automatic test_reset();
      R = 1'b0; TRAFFIC = '0; MANUAL = '0;
      push_cnt(G, 0, 4, 2);
      for (int i = 0; i < 2; i++) check_cycle("reset");
      end_check("reset");
   endtask

   task automatic test_no_traffic();
      R = 1'b0; TRAFFIC = '0; MANUAL = '0;
      push_phase(G, 0, 4, 4); push_phase(Y, 0, 2, 2); push_phase(AR, 0, 1, 1);
      push_phase(G, 1, 4, 1);
      for (int i = 0; i < 16; i++) begin
         check_cycle("no_traffic");
         if (i == 0) R = 1'b1;
      end
      end_check("no_traffic");
   endtask

   task automatic test_extension();
      R = 1'b0; TRAFFIC = 3'b001; MANUAL = '0;
      push_phase(G, 0, 4, 4); push_phase(G, 0, 3, 3); push_phase(Y, 0, 2, 2);
      push_phase(AR, 0, 1, 1); push_phase(G, 0, 4, 1);
      for (int i = 0; i < 22; i++) begin
         check_cycle("extension");
         if (i == 0) R = 1'b1;
      end
      end_check("extension");
   endtask

   task automatic test_skip_empty();
      R = 1'b0; TRAFFIC = 3'b100; MANUAL = '0;
      push_phase(G, 0, 4, 4); push_phase(Y, 0, 2, 2); push_phase(AR, 0, 1, 1);
      push_phase(G, 2, 4, 1);
      for (int i = 0; i < 16; i++) begin
         check_cycle("skip_empty");
         if (i == 0) R = 1'b1;
      end
      end_check("skip_empty");
   endtask

   task automatic test_manual_preempt();
      R = 1'b0; TRAFFIC = '0; MANUAL = '0;
      push_phase(G, 0, 4, 1); push_cnt(G, 0, 3, 1); push_phase(Y, 0, 2, 2);
      push_phase(AR, 0, 1, 1); push_phase(G, 1, 4, 4); push_phase(Y, 1, 2, 2);
      push_phase(AR, 1, 1, 1); push_phase(G, 2, 4, 1);
      for (int i = 0; i < 25; i++) begin
         check_cycle("manual_preempt");
         if (i == 0) R = 1'b1;
         if (i == 2) MANUAL = 3'b010;
         if (i == 3) MANUAL = '0;
      end
      end_check("manual_preempt");
   endtask

   task automatic test_back_to_back();
      R = 1'b0; TRAFFIC = '0; MANUAL = '0;
      push_phase(G, 0, 4, 4); push_phase(Y, 0, 2, 2); push_phase(AR, 0, 1, 1);
      push_phase(G, 1, 4, 4); push_phase(Y, 1, 2, 2); push_phase(AR, 1, 1, 1);
      push_cnt(G, 0, 4, 1); push_phase(Y, 0, 2, 2); push_phase(AR, 0, 1, 1);
      push_phase(G, 2, 4, 4);
      for (int i = 0; i < 43; i++) begin
         check_cycle("back_to_back");
         if (i == 0)  R = 1'b1;
         if (i == 22) MANUAL = 3'b101;
         if (i == 23) MANUAL = '0;
      end
      end_check("back_to_back");
   endtask

   task automatic test_reset_mid_phase();
      R = 1'b0; TRAFFIC = 3'b100; MANUAL = '0;
      push_phase(G, 0, 4, 4); push_phase(Y, 0, 2, 2); push_phase(AR, 0, 1, 1);
      push_phase(G, 2, 4, 4); push_phase(G, 2, 3, 3); push_cnt(Y, 2, 2, 1);
      push_phase(G, 0, 4, 4); push_phase(G, 0, 3, 3); push_phase(Y, 0, 2, 2);
      for (int i = 0; i < 47; i++) begin
         check_cycle("reset_mid_phase");
         if (i == 0)  R = 1'b1;
         if (i == 27) MANUAL = 3'b010;
         if (i == 28) begin MANUAL = '0; R = 1'b0; end
         if (i == 29) begin R = 1'b1; TRAFFIC = 3'b001; end
      end
      end_check("reset_mid_phase");
   endtask

   initial begin
      R = 1'b0; TRAFFIC = '0; MANUAL = '0;
      test_reset();
      test_no_traffic();
      test_extension();
      test_skip_empty();
      test_manual_preempt();
      test_back_to_back();
      test_reset_mid_phase();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
